// File: rtl/rv32_pkg.sv
// Shared register-file widths, writeback request payload and arbitration modes.
package rv32_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned STALL_W = 16;

    localparam logic [AW-1:0] REG_ZERO = AW'(0);

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requesters, register-file write port and read bypass bundle.
interface regfile_wb_arbiter_if;
    import rv32_pkg::*;

    logic                  alu_valid;
    logic [AW-1:0]         alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;
    logic                  lsu_valid;
    logic [AW-1:0]         lsu_rd;
    logic [XLEN-1:0]       lsu_data;
    logic                  lsu_ready;
    logic                  WE3;
    logic [AW-1:0]         A3;
    logic [XLEN-1:0]       WD3;
    logic [AW-1:0]         A1;
    logic [AW-1:0]         A2;
    logic [XLEN-1:0]       RD1;
    logic [XLEN-1:0]       RD2;
    logic [XLEN-1:0]       RD1_fwd;
    logic [XLEN-1:0]       RD2_fwd;
    logic [STALL_W-1:0]    stall_cnt;

    // Requesters and register file side
    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output A1, A2, RD1, RD2,
        input  alu_ready, lsu_ready, WE3, A3, WD3, RD1_fwd, RD2_fwd, stall_cnt
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  A1, A2, RD1, RD2,
        output alu_ready, lsu_ready, WE3, A3, WD3, RD1_fwd, RD2_fwd, stall_cnt
    );

endinterface

// File: rtl/wb_rr_arb2.sv
// Two-way arbiter: round-robin on contention, or fixed priority to requester 1.
module wb_rr_arb2
    import rv32_pkg::*;
#(
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [1:0] valid,
    output logic [1:0] grant_c
);

    logic rr_last;

    // Grant decode; nothing is granted while reset is asserted
    always_comb begin
        grant_c = 2'b00;
        if (areset) begin
            case (valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11: begin
                    if (PRIO_MODE == PRIO_FIXED) grant_c = 2'b10;
                    else                         grant_c = rr_last ? 2'b01 : 2'b10;
                end
                default: grant_c = 2'b00;
            endcase
        end
    end

    // Remember the last granted index; reset favours requester 0 on the first tie
    always_ff @(posedge clk or negedge areset) begin
        if (!areset)         rr_last <= 1'b1;
        else if (|grant_c)   rr_last <= grant_c[1];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and LSU writeback, with bypass.
module regfile_wb_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic                 clk,
    input  logic                 areset,
    regfile_wb_arbiter_if.slave  bus
);

    wb_req_t             alu_req;
    wb_req_t             lsu_req;
    wb_req_t             win_req;
    logic [1:0]          grant_c;
    logic                refused_c;
    logic                we3_q;
    logic [AW-1:0]       a3_q;
    logic [XLEN-1:0]     wd3_q;
    logic [STALL_W-1:0]  stall_q;

    assign alu_req = '{valid: bus.alu_valid, rd: bus.alu_rd, data: bus.alu_data};
    assign lsu_req = '{valid: bus.lsu_valid, rd: bus.lsu_rd, data: bus.lsu_data};

    wb_rr_arb2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk     (clk),
        .areset  (areset),
        .valid   ({lsu_req.valid, alu_req.valid}),
        .grant_c (grant_c)
    );

    assign bus.alu_ready = grant_c[0];
    assign bus.lsu_ready = grant_c[1];

    // Select the granted payload and flag any refused valid requester
    always_comb begin
        win_req   = alu_req;
        refused_c = 1'b0;
        if (grant_c[1]) win_req = lsu_req;
        if (alu_req.valid && !grant_c[0]) refused_c = 1'b1;
        if (lsu_req.valid && !grant_c[1]) refused_c = 1'b1;
    end

    // Write stage: refilled by a grant to a non-zero register, otherwise cleared
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            we3_q <= 1'b0;
            a3_q  <= REG_ZERO;
            wd3_q <= XLEN'(0);
        end else if ((|grant_c) && win_req.valid && (win_req.rd != REG_ZERO)) begin
            we3_q <= 1'b1;
            a3_q  <= win_req.rd;
            wd3_q <= win_req.data;
        end else begin
            we3_q <= 1'b0;
            a3_q  <= REG_ZERO;
            wd3_q <= XLEN'(0);
        end
    end

    // Saturating count of cycles in which a valid requester was refused
    always_ff @(posedge clk or negedge areset) begin
        if (!areset)                                stall_q <= STALL_W'(0);
        else if (refused_c && (stall_q != '1))      stall_q <= stall_q + STALL_W'(1);
    end

    // Bypass the staged write onto both read ports
    always_comb begin
        bus.RD1_fwd = bus.RD1;
        bus.RD2_fwd = bus.RD2;
        if (we3_q && (a3_q != REG_ZERO) && (a3_q == bus.A1)) bus.RD1_fwd = wd3_q;
        if (we3_q && (a3_q != REG_ZERO) && (a3_q == bus.A2)) bus.RD2_fwd = wd3_q;
    end

    assign bus.WE3       = we3_q;
    assign bus.A3        = a3_q;
    assign bus.WD3       = wd3_q;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench: round-robin (u0) and fixed-priority (u1) instances share one stimulus stream.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd, a1, a2;
    logic [31:0] alu_data, lsu_data, rd1, rd2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus0 ();
    regfile_wb_arbiter_if bus1 ();

    assign bus0.alu_valid = alu_valid;  assign bus1.alu_valid = alu_valid;
    assign bus0.alu_rd    = alu_rd;     assign bus1.alu_rd    = alu_rd;
    assign bus0.alu_data  = alu_data;   assign bus1.alu_data  = alu_data;
    assign bus0.lsu_valid = lsu_valid;  assign bus1.lsu_valid = lsu_valid;
    assign bus0.lsu_rd    = lsu_rd;     assign bus1.lsu_rd    = lsu_rd;
    assign bus0.lsu_data  = lsu_data;   assign bus1.lsu_data  = lsu_data;
    assign bus0.A1 = a1;  assign bus1.A1 = a1;
    assign bus0.A2 = a2;  assign bus1.A2 = a2;
    assign bus0.RD1 = rd1; assign bus1.RD1 = rd1;
    assign bus0.RD2 = rd2; assign bus1.RD2 = rd2;

    regfile_wb_arbiter #(.PRIO_MODE(0)) u_rr (.clk(clk), .areset(areset), .bus(bus0));
    regfile_wb_arbiter #(.PRIO_MODE(1)) u_fx (.clk(clk), .areset(areset), .bus(bus1));

    // Actual outputs gathered per instance
    logic        act_ardy [2];
    logic        act_lrdy [2];
    logic        act_we   [2];
    logic [4:0]  act_a    [2];
    logic [31:0] act_d    [2];
    logic [31:0] act_f1   [2];
    logic [31:0] act_f2   [2];
    logic [15:0] act_st   [2];
    assign act_ardy[0] = bus0.alu_ready; assign act_ardy[1] = bus1.alu_ready;
    assign act_lrdy[0] = bus0.lsu_ready; assign act_lrdy[1] = bus1.lsu_ready;
    assign act_we[0]   = bus0.WE3;       assign act_we[1]   = bus1.WE3;
    assign act_a[0]    = bus0.A3;        assign act_a[1]    = bus1.A3;
    assign act_d[0]    = bus0.WD3;       assign act_d[1]    = bus1.WD3;
    assign act_f1[0]   = bus0.RD1_fwd;   assign act_f1[1]   = bus1.RD1_fwd;
    assign act_f2[0]   = bus0.RD2_fwd;   assign act_f2[1]   = bus1.RD2_fwd;
    assign act_st[0]   = bus0.stall_cnt; assign act_st[1]   = bus1.stall_cnt;

    // Behavioural model: instance 0 round-robin, instance 1 LSU-first
    logic        m_rr    [2];
    logic        m_we    [2];
    logic [4:0]  m_a     [2];
    logic [31:0] m_d     [2];
    logic [15:0] m_stall [2];
    logic [31:0] m_rf    [2][32];

    // Which requester wins this cycle, as a {lsu, alu} ready pair
    function automatic logic [1:0] exp_grant(int i);
        int winner;
        if (!areset) return 2'b00;
        if (alu_valid && lsu_valid) begin
            if (i == 1) winner = 1;
            else        winner = (m_rr[i] == 1'b1) ? 0 : 1;
            return (winner == 1) ? 2'b10 : 2'b01;
        end
        return {lsu_valid, alu_valid};
    endfunction

    function automatic logic [31:0] exp_fwd(int i, logic [4:0] addr, logic [31:0] raw);
        if (m_we[i] && m_a[i] != 5'd0 && m_a[i] == addr) return m_d[i];
        return raw;
    endfunction

    always @(posedge clk or negedge areset) begin
        for (int i = 0; i < 2; i++) begin
            if (!areset) begin
                m_rr[i]    <= 1'b1;
                m_we[i]    <= 1'b0;
                m_a[i]     <= 5'd0;
                m_d[i]     <= 32'd0;
                m_stall[i] <= 16'd0;
            end else begin
                logic [1:0]  g;
                logic [4:0]  wrd;
                logic [31:0] wdat;
                g = exp_grant(i);
                if (m_we[i]) m_rf[i][m_a[i]] <= m_d[i];
                wrd  = g[1] ? lsu_rd : alu_rd;
                wdat = g[1] ? lsu_data : alu_data;
                if (g != 2'b00) m_rr[i] <= g[1];
                if (g != 2'b00 && wrd != 5'd0) begin
                    m_we[i] <= 1'b1;
                    m_a[i]  <= wrd;
                    m_d[i]  <= wdat;
                end else begin
                    m_we[i] <= 1'b0;
                    m_a[i]  <= 5'd0;
                    m_d[i]  <= 32'd0;
                end
                if (((alu_valid && !g[0]) || (lsu_valid && !g[1])) && m_stall[i] != 16'hFFFF)
                    m_stall[i] <= m_stall[i] + 16'd1;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic [1:0] g;
            g = exp_grant(i);
            chk($sformatf("u%0d_alu_ready", i), 32'(act_ardy[i]), 32'(g[0]));
            chk($sformatf("u%0d_lsu_ready", i), 32'(act_lrdy[i]), 32'(g[1]));
            chk($sformatf("u%0d_WE3", i), 32'(act_we[i]), 32'(m_we[i]));
            if (m_we[i]) begin
                chk($sformatf("u%0d_A3", i), 32'(act_a[i]), 32'(m_a[i]));
                chk($sformatf("u%0d_WD3", i), act_d[i], m_d[i]);
            end
            chk($sformatf("u%0d_RD1_fwd", i), act_f1[i], exp_fwd(i, a1, rd1));
            chk($sformatf("u%0d_RD2_fwd", i), act_f2[i], exp_fwd(i, a2, rd2));
            chk($sformatf("u%0d_stall_cnt", i), 32'(act_st[i]), 32'(m_stall[i]));
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) compare_all();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_seq [4];
    logic [4:0] a3_seq [4];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_rr[i] = 1'b1; m_we[i] = 1'b0; m_a[i] = 5'd0; m_d[i] = 32'd0; m_stall[i] = 16'd0;
            for (int r = 0; r < 32; r++) m_rf[i][r] = 32'd0;
        end
        rr_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        a3_seq = '{5'd3, 5'd4, 5'd3, 5'd4};
        alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_rd = 5'd9; lsu_rd = 5'd10; alu_data = 32'h1111_1111; lsu_data = 32'h2222_2222;
        a1 = 5'd0; a2 = 5'd0; rd1 = 32'd0; rd2 = 32'd0;

        // Reset held two cycles with both requesters valid
        repeat (2) step();
        #2;
        chk("rst_WE3", 32'(bus0.WE3), 32'd0);
        chk("rst_A3", 32'(bus0.A3), 32'd0);
        chk("rst_WD3", bus0.WD3, 32'd0);
        chk("rst_stall", 32'(bus0.stall_cnt), 32'd0);
        chk("rst_alu_ready", 32'(bus0.alu_ready), 32'd0);
        chk("rst_lsu_ready", 32'(bus1.lsu_ready), 32'd0);
        step();
        areset = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;

        // Single ALU request to x5
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #2;
        chk("single_alu_ready", 32'(bus0.alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        #2;
        chk("single_WE3", 32'(bus0.WE3), 32'd1);
        chk("single_A3", 32'(bus0.A3), 32'd5);
        chk("single_WD3", bus0.WD3, 32'hDEAD_BEEF);
        step();
        #2;
        chk("single_reg5", m_rf[0][5], 32'hDEAD_BEEF);

        // LSU write to x0 is accepted but not staged
        step();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_1234;
        #2;
        chk("x0_lsu_ready", 32'(bus0.lsu_ready), 32'd1);
        step();
        lsu_valid = 1'b0;
        #2;
        chk("x0_WE3", 32'(bus0.WE3), 32'd0);
        step();
        #2;
        chk("x0_reg0", m_rf[0][0], 32'd0);

        // Contention: round-robin alternates on u0, LSU always wins on u1
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
                lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444_4444;
            end
            #2;
            chk($sformatf("rr_grant%0d", k), 32'({bus0.lsu_ready, bus0.alu_ready}), 32'(rr_seq[k]));
            if (k > 0) chk($sformatf("rr_A3_%0d", k - 1), 32'(bus0.A3), 32'(a3_seq[k - 1]));
        end
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #2;
        chk("rr_A3_3", 32'(bus0.A3), 32'(a3_seq[3]));
        chk("rr_stall", 32'(bus0.stall_cnt), 32'd4);
        chk("fx_stall_contention", 32'(bus1.stall_cnt), 32'd4);

        // Fresh reset, then fixed priority under contention
        step();
        areset = 1'b0;
        step();
        step();
        areset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 0) begin
                alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h0000_00AA;
                lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h0000_00BB;
            end
            #2;
            chk($sformatf("fx_lsu_ready%0d", k), 32'(bus1.lsu_ready), 32'd1);
            chk($sformatf("fx_alu_ready%0d", k), 32'(bus1.alu_ready), 32'd0);
        end
        step();
        lsu_valid = 1'b0;
        #2;
        chk("fx_alu_after_drop", 32'(bus1.alu_ready), 32'd1);
        chk("fx_stall", 32'(bus1.stall_cnt), 32'd3);

        // Bypass of a staged write to x7, then reset mid-stage
        step();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA5A5_A5A5;
        step();
        alu_valid = 1'b0;
        a1 = 5'd7; rd1 = 32'd0; a2 = 5'd8; rd2 = 32'h0BAD_F00D;
        #2;
        chk("byp_RD1_fwd", bus0.RD1_fwd, 32'hA5A5_A5A5);
        chk("byp_RD2_fwd", bus0.RD2_fwd, 32'h0BAD_F00D);
        chk("byp_fx_RD1_fwd", bus1.RD1_fwd, 32'hA5A5_A5A5);
        #1;
        areset = 1'b0;
        #1;
        chk("midrst_WE3", 32'(bus0.WE3), 32'd0);
        chk("midrst_fx_WE3", 32'(bus1.WE3), 32'd0);
        chk("midrst_RD1_fwd", bus0.RD1_fwd, 32'd0);
        compare_all();
        alu_valid = 1'b1;
        #1;
        chk("midrst_alu_ready", 32'(bus0.alu_ready), 32'd0);
        step();
        step();
        areset = 1'b1;
        #2;
        chk("rel_alu_ready", 32'(bus0.alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        #2;
        chk("rel_WE3", 32'(bus0.WE3), 32'd1);
        chk("rel_A3", 32'(bus0.A3), 32'd7);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
